// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - multi-cycle restoring divider for the ALU DIV/REM path
module seq_restoring_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] mag_b_q;
  logic [CW-1:0]    count;
  logic             neg_q, neg_r;

  logic             accept, a_neg, b_neg, div_zero, last_step, step_ok;
  logic [WIDTH-1:0] mag_a, mag_b, r_next, q_next;
  logic [WIDTH:0]   r_shift, t_diff;

  always_comb begin
    accept    = start && (state != S_CALC);
    a_neg     = is_signed && dividend[WIDTH-1];
    b_neg     = is_signed && divisor[WIDTH-1];
    mag_a     = a_neg ? -dividend : dividend;
    mag_b     = b_neg ? -divisor : divisor;
    div_zero  = (divisor == '0);
    last_step = (count == CW'(WIDTH - 1));

    // Remainder stays below |b|, so only the shifted-in bit needs the extra MSB.
    r_shift = {rem_q, quo_q[WIDTH-1]};
    t_diff  = r_shift - {1'b0, mag_b_q};
    step_ok = ~t_diff[WIDTH];
    r_next  = step_ok ? t_diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
    q_next  = {quo_q[WIDTH-2:0], step_ok};
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) state_next = div_zero ? S_DONE : S_CALC;
        else        state_next = S_IDLE;
      end
      S_CALC: begin
        if (last_step) state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state == S_CALC);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      mag_b_q     <= '0;
      count       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        neg_q   <= a_neg ^ b_neg;
        neg_r   <= a_neg;
        mag_b_q <= mag_b;
        quo_q   <= mag_a;
        rem_q   <= '0;
        count   <= '0;
        if (div_zero) begin
          quotient    <= '1;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
        end
      end else if (state == S_CALC) begin
        rem_q <= r_next;
        quo_q <= q_next;
        count <= count + 1'b1;
        if (last_step) begin
          quotient    <= neg_q ? -q_next : q_next;
          remainder   <= neg_r ? -r_next : r_next;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - directed self-checking bench for seq_restoring_divider
module tb_seq_restoring_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int n_cmp = 0;
  int n_err = 0;

  seq_restoring_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for the accept edge, then runs until done; the inject cycle
  // pulses start with 9/4 while busy to prove it is ignored.
  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_q,
                        input logic [31:0] exp_r, input logic exp_dbz, input int inject_at);
    int n;
    logic busy_ok;
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    step();
    start   = 1'b0;
    n       = 1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && n < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (n == inject_at) begin
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd4;
      end else begin
        start = 1'b0;
      end
      step();
      n++;
    end
    start = 1'b0;
    chk({tag, " latency"}, n, exp_lat);
    chk({tag, " busy_while_calc"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, " busy_in_done"}, {31'd0, busy}, 32'd0);
    chk({tag, " quotient"}, quotient, exp_q);
    chk({tag, " remainder"}, remainder, exp_r);
    chk({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, exp_dbz});
  endtask

  initial begin
    logic saw_done;
    rst = 1'b0;
    step();
    step();
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset quotient", quotient, 32'd0);
    chk("reset remainder", remainder, 32'd0);
    chk("reset dbz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b1;
    step();

    run_op("u100/7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0, 0);
    step();
    chk("done one cycle", {31'd0, done}, 32'd0);
    chk("q held", quotient, 32'd14);
    chk("r held", remainder, 32'd2);

    run_op("s-100/7", 1'b1, 32'hFFFF_FF9C, 32'd7, 33, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 0);
    run_op("s100/-7", 1'b1, 32'd100, 32'hFFFF_FFF9, 33, 32'hFFFF_FFF2, 32'd2, 1'b0, 0);
    run_op("s-7/-2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 33, 32'd3, 32'hFFFF_FFFF, 1'b0, 0);
    step();

    run_op("u5/0", 1'b0, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 32'd5, 1'b1, 0);
    step();
    chk("dbz held", {31'd0, div_by_zero}, 32'd1);
    run_op("s-5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 0);
    run_op("u9/4 clears dbz", 1'b0, 32'd9, 32'd4, 33, 32'd2, 32'd1, 1'b0, 0);
    step();

    run_op("smin/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0, 1'b0, 0);
    run_op("umax/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
    run_op("u8000/ffff", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000, 1'b0, 0);
    step();

    run_op("ignored start", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0, 10);
    run_op("back2back 9/4", 1'b0, 32'd9, 32'd4, 33, 32'd2, 32'd1, 1'b0, 0);
    step();

    is_signed = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 15; c++) step();
    chk("pre-abort busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort quotient", quotient, 32'd0);
    chk("abort remainder", remainder, 32'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (done === 1'b1) saw_done = 1'b1;
    end
    chk("abort no done", {31'd0, saw_done}, 32'd0);
    run_op("after abort", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
